// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the unified memory.
// slave  : arbiter view (takes requests, drives memory strobes)
// master : environment view (core requesters plus memory device)
interface mem_port_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    // Instruction fetch port
    logic             i_req;
    logic [WIDTH-1:0] i_addr;
    logic [WIDTH-1:0] i_rdata;
    logic             i_ack;
    logic             i_err;
    // Load/store data port
    logic             d_req;
    logic             d_we;
    logic [WIDTH-1:0] d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic [WIDTH-1:0] d_rdata;
    logic             d_ack;
    logic             d_err;
    // Memory side
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready;
    // Owner of the current or most recent access
    logic             grant;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_ack, i_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output grant
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_ack, i_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  grant
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one single-port memory between instruction fetch and
// load/store. Accesses are serialized through IDLE -> ACC -> RESP with a per-access
// timeout; each requester gets a one-cycle ack with its read data and error flag.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise
// the data port always wins a tie.
module mem_port_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned     CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0]  i_rdata_q, i_rdata_d;
    logic [WIDTH-1:0]  d_rdata_q, d_rdata_d;
    logic              i_err_q, i_err_d;
    logic              d_err_q, d_err_d;
    logic              win_data;

    // Pick the winner among the current requests (1 = data port)
    always_comb begin
        win_data = bus.d_req;
        if (bus.i_req && bus.d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_data = ~last_grant_q;
`else
            win_data = 1'b1;
`endif
        end
    end

    // Next-state logic for the access FSM and its datapath registers
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_err_d      = i_err_q;
        d_err_d      = d_err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.i_req || bus.d_req) begin
                    grant_d      = win_data;
                    last_grant_d = win_data;
                    wait_cnt_d   = '0;
                    state_d      = StAcc;
                    if (win_data) begin
                        mem_addr_d  = bus.d_addr;
                        mem_we_d    = bus.d_we;
                        mem_wdata_d = bus.d_wdata;
                    end else begin
                        // Fetches never write; write data is left as is
                        mem_addr_d = bus.i_addr;
                        mem_we_d   = 1'b0;
                    end
                end
            end
            StAcc: begin
                // A ready in the last allowed cycle still wins over the timeout
                if (bus.mem_ready) begin
                    state_d = StResp;
                    if (grant_q) begin
                        d_rdata_d = bus.mem_rdata;
                        d_err_d   = 1'b0;
                    end else begin
                        i_rdata_d = bus.mem_rdata;
                        i_err_d   = 1'b0;
                    end
                end else if (wait_cnt_q == CntMax) begin
                    state_d = StResp;
                    if (grant_q) begin
                        d_rdata_d = '0;
                        d_err_d   = 1'b1;
                    end else begin
                        i_rdata_d = '0;
                        i_err_d   = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wait_cnt_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_err_q      <= i_err_d;
            d_err_q      <= d_err_d;
        end
    end

    // Strobes decode straight from the registered state
    always_comb begin
        bus.mem_req   = (state_q == StAcc);
        bus.i_ack     = (state_q == StResp) && !grant_q;
        bus.d_ack     = (state_q == StResp) && grant_q;
        bus.mem_we    = mem_we_q;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        bus.i_rdata   = i_rdata_q;
        bus.d_rdata   = d_rdata_q;
        bus.i_err     = i_err_q;
        bus.d_err     = d_err_q;
        bus.grant     = grant_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter. A transaction-level model decides
// arbitration and completion timing from the request/latency rules and queues the
// expected memory access and ack; a monitor checks them as the DUT presents them.
module tb_mem_port_arbiter;

    localparam int unsigned W   = 32;
    localparam int unsigned TO  = 4;
    localparam int unsigned NACC = 150;

    typedef struct {
        bit          port;   // 1 = data
        logic [W-1:0] addr;
        bit          we;
        logic [W-1:0] wdata;
        logic [W-1:0] rdata;
        bit          err;
        int unsigned acc_start;
        int unsigned acc_end;
        int unsigned ack;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    bit mon_en = 1'b0;

    exp_t q[$];
    int unsigned delay_tab[1024];
    logic [W-1:0] mem_ref[16];
    logic [W-1:0] mem_dev[16];

    mem_port_arbiter_if #(.WIDTH(W)) bus ();

    mem_port_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " mem_req"},   64'(bus.mem_req),   64'd0);
        check({tag, " mem_we"},    64'(bus.mem_we),    64'd0);
        check({tag, " mem_addr"},  64'(bus.mem_addr),  64'd0);
        check({tag, " mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        check({tag, " i_ack"},     64'(bus.i_ack),     64'd0);
        check({tag, " d_ack"},     64'(bus.d_ack),     64'd0);
        check({tag, " i_err"},     64'(bus.i_err),     64'd0);
        check({tag, " d_err"},     64'(bus.d_err),     64'd0);
        check({tag, " i_rdata"},   64'(bus.i_rdata),   64'd0);
        check({tag, " d_rdata"},   64'(bus.d_rdata),   64'd0);
        check({tag, " grant"},     64'(bus.grant),     64'd0);
    endtask

    // Memory device: answers each access after its planned number of wait cycles
    int unsigned dev_k = 0;
    int unsigned dev_cnt = 0;
    bit dev_act = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                if (dev_cnt == delay_tab[dev_k]) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_dev[bus.mem_addr[5:2]];
                    if (bus.mem_we) mem_dev[bus.mem_addr[5:2]] = bus.mem_wdata;
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom;
                end
                dev_cnt++;
                dev_act = 1'b1;
            end else begin
                if (dev_act) dev_k++;
                dev_act = 1'b0;
                dev_cnt = 0;
                // Noise outside an access must be ignored
                bus.mem_ready = 1'($urandom_range(0, 1));
                bus.mem_rdata = $urandom;
            end
        end
    end

    // Monitor: memory strobes and acks against the queued expectations
    initial begin
        exp_t e;
        bit in_acc;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                in_acc = (q.size() > 0) && (cyc >= q[0].acc_start) && (cyc <= q[0].acc_end);
                check("mem_req", 64'(bus.mem_req), 64'(in_acc));
                if (in_acc) begin
                    check("mem_addr", 64'(bus.mem_addr), 64'(q[0].addr));
                    check("mem_we", 64'(bus.mem_we), 64'(q[0].we));
                    if (q[0].we) check("mem_wdata", 64'(bus.mem_wdata), 64'(q[0].wdata));
                end
                if (bus.i_ack || bus.d_ack) begin
                    if (q.size() == 0) begin
                        check("unexpected ack", 64'(1), 64'(0));
                    end else begin
                        e = q.pop_front();
                        check("ack cycle", 64'(cyc), 64'(e.ack));
                        check("i_ack", 64'(bus.i_ack), 64'(!e.port));
                        check("d_ack", 64'(bus.d_ack), 64'(e.port));
                        check("grant", 64'(bus.grant), 64'(e.port));
                        if (e.port) begin
                            check("d_rdata", 64'(bus.d_rdata), 64'(e.rdata));
                            check("d_err", 64'(bus.d_err), 64'(e.err));
                        end else begin
                            check("i_rdata", 64'(bus.i_rdata), 64'(e.rdata));
                            check("i_err", 64'(bus.i_err), 64'(e.err));
                        end
                    end
                end else if (q.size() > 0 && cyc > q[0].ack) begin
                    check("missing ack", 64'(0), 64'(1));
                    void'(q.pop_front());
                end
            end
        end
    end

    // Stimulus plus transaction-level reference model
    initial begin
        int unsigned c, model_idle, n_acc, d, len, due_i, due_d, t0;
        bit pend_i, pend_d, last_g, win, issuing, dwe, ok;
        logic [W-1:0] ia, da, dw;
        logic [3:0] idx;
        exp_t e;

        for (int k = 0; k < 1024; k++) begin
            case ($urandom_range(0, 7))
                0, 1:    delay_tab[k] = 0;
                2:       delay_tab[k] = 1;
                3:       delay_tab[k] = 2;
                4:       delay_tab[k] = TO - 1;
                5:       delay_tab[k] = TO;
                6:       delay_tab[k] = TO + 3;
                default: delay_tab[k] = 0;
            endcase
        end
        for (int k = 0; k < 16; k++) begin
            mem_ref[k] = $urandom;
            mem_dev[k] = mem_ref[k];
        end

        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        mon_en = 1'b1;
        model_idle = cyc + 1;
        last_g = 1'b1;
        n_acc = 0;
        pend_i = 1'b0; pend_d = 1'b0;
        due_i = 0; due_d = 0;
        ia = '0; da = '0; dw = '0; dwe = 1'b0;
        issuing = 1'b1;
        t0 = cyc;

        while (issuing || pend_i || pend_d || q.size() > 0) begin
            @(posedge clk);
            #1;
            c = cyc;
            if (c - t0 > 20000) begin
                check("run budget", 64'(0), 64'(1));
                break;
            end
            if (pend_i && c == due_i + 1) pend_i = 1'b0;
            if (pend_d && c == due_d + 1) pend_d = 1'b0;
            if (n_acc >= NACC) issuing = 1'b0;

            if (issuing && !pend_i && $urandom_range(0, 2) != 0) begin
                pend_i = 1'b1;
                idx = 4'($urandom_range(0, 15));
                ia = 32'h100 | (W'(idx) << 2);
            end
            if (issuing && !pend_d && $urandom_range(0, 2) != 0) begin
                pend_d = 1'b1;
                idx = 4'($urandom_range(0, 15));
                da = 32'h2000 | (W'(idx) << 2);
                dwe = 1'($urandom_range(0, 1));
                dw = $urandom;
            end
            bus.i_req = pend_i;
            bus.i_addr = pend_i ? ia : W'($urandom);
            bus.d_req = pend_d;
            bus.d_addr = pend_d ? da : W'($urandom);
            bus.d_we = pend_d ? dwe : 1'($urandom_range(0, 1));
            bus.d_wdata = pend_d ? dw : W'($urandom);

            if (c == model_idle) begin
                if (pend_i || pend_d) begin
                    if (pend_i && pend_d) begin
`ifdef ARB_ROUND_ROBIN_EN
                        win = !last_g;
`else
                        win = 1'b1;
`endif
                    end else begin
                        win = pend_d;
                    end
                    last_g = win;
                    d = delay_tab[n_acc];
                    n_acc++;
                    ok = (d < TO);
                    len = ok ? d + 1 : TO;
                    e.port = win;
                    e.addr = win ? da : ia;
                    e.we = win ? dwe : 1'b0;
                    e.wdata = dw;
                    e.err = !ok;
                    e.rdata = ok ? mem_ref[e.addr[5:2]] : '0;
                    if (ok && e.we) mem_ref[e.addr[5:2]] = dw;
                    e.acc_start = c + 1;
                    e.acc_end = c + len;
                    e.ack = c + len + 1;
                    q.push_back(e);
                    if (win) due_d = e.ack;
                    else due_i = e.ack;
                    model_idle = c + len + 2;
                end else begin
                    model_idle = c + 1;
                end
            end
        end

        // Reset during the second cycle of a long load: abandoned, no ack
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        delay_tab[n_acc] = 1000;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2010;
        @(posedge clk);
        #1;
        check("rst-mid first acc mem_req", 64'(bus.mem_req), 64'd1);
        check("rst-mid mem_addr", 64'(bus.mem_addr), 64'h2010);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.d_req = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst-mid");
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("post-rst d_ack", 64'(bus.d_ack), 64'd0);
            check("post-rst mem_req", 64'(bus.mem_req), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-port memory between the core's instruction-fetch port and its load/store data port. It sits between the RISC core (fetch address from the multicycle instruction decoder, data address/write data from the datapath) and a unified instruction/data memory. It serializes accesses through a registered FSM with a ready handshake and a per-access timeout. Each requester gets a one-cycle acknowledge together with its read data.

## Interface
Parameters:
- WIDTH, 32, address and data width.
- TIMEOUT, 16, maximum cycles an access waits for mem_ready before it aborts with an error. Must be ≥ 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- i_req  in  1  instruction fetch request; held high until i_ack.
- i_addr  in  WIDTH  fetch address; held stable while i_req is high.
- i_rdata  out  WIDTH  fetched instruction; valid while i_ack is high.
- i_ack  out  1  one-cycle fetch completion pulse.
- i_err  out  1  fetch timed out; qualified by i_ack.
- d_req  in  1  data access request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load; held stable while d_req is high.
- d_addr  in  WIDTH  data address.
- d_wdata  in  WIDTH  store data.
- d_rdata  out  WIDTH  load data; valid while d_ack is high.
- d_ack  out  1  one-cycle data completion pulse.
- d_err  out  1  data access timed out; qualified by d_ack.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable; 0 for every fetch.
- mem_addr  out  WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data; valid when mem_ready is high.
- mem_ready  in  1  memory completes the current access in this cycle.
- grant  out  1  owner of the current or most recent access (0 = fetch, 1 = data).

## Operation
- FSM states: IDLE, ACC, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, resolve per Configuration.
  - On a grant: latch the winner's address, we and wdata into mem_addr, mem_we and mem_wdata; set grant; clear wait_cnt; go to ACC.
- ACC:
  - mem_req = 1; the mem_* outputs stay constant.
  - If mem_ready = 1: capture mem_rdata into the winner's rdata register, keep err = 0, go to RESP.
  - Else if wait_cnt = TIMEOUT-1: set the winner's err, load 0 into its rdata register, go to RESP.
  - Else increment wait_cnt.
- RESP:
  - mem_req = 0.
  - The winner's ack = 1 for exactly this cycle; the loser's ack stays 0.
  - Go to IDLE.
- mem_req is 0 in IDLE and RESP. mem_addr, mem_we and mem_wdata hold their last value outside ACC.
- rdata and err registers hold their value until the next completion for the same port.
- last_grant updates on every grant and is used only for round-robin.
- Requests that arrive while ACC or RESP is in progress wait and are arbitrated in the next IDLE cycle.
- wait_cnt is $clog2(TIMEOUT) bits wide and never wraps, because it is compared against TIMEOUT-1.

## Timing
- Reset (rst = 0 at an edge):
  - state = IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata = 0.
  - i_ack, d_ack, i_err, d_err, i_rdata, d_rdata = 0.
  - grant = 0, last_grant = 1, wait_cnt = 0.
- Reset mid-access: the access is abandoned. mem_req is 0 from the next cycle and no ack is issued.
- Latency: request sampled high in IDLE at edge N → ACC from N+1. mem_ready high in cycle k of ACC → RESP (ack) in the following cycle → IDLE one cycle later.
- Minimum spacing between accesses is 3 cycles.
- A timed-out access acks TIMEOUT+1 cycles after the grant edge.
- A requester that keeps req high through RESP is treated as issuing a new request and is re-arbitrated in the next IDLE cycle.
- mem_ready is ignored in IDLE and RESP.

## Configuration
- Macro ARB_ROUND_ROBIN_EN:
  - Defined: on a tie, grant the port not recorded in last_grant. Reset value last_grant = 1, so the first tie goes to fetch.
  - Undefined: fixed priority, data always wins ties. last_grant is still maintained but has no effect.

## Test plan
- Single fetch: rst released, i_req = 1, i_addr = 0x100, mem_ready = 1 in the first ACC cycle, mem_rdata = 0x00A00093 → mem_addr = 0x100, mem_we = 0; i_ack for one cycle with i_rdata = 0x00A00093, i_err = 0; back in IDLE 3 cycles after the grant.
- Store with wait: d_req = 1, d_we = 1, d_addr = 0x2000, d_wdata = 0xDEADBEEF, mem_ready after 3 ACC cycles → mem_we = 1 and mem_wdata = 0xDEADBEEF stable throughout; d_ack one cycle after mem_ready.
- Tie, both builds: i_req and d_req high together for two transactions → with ARB_ROUND_ROBIN_EN: fetch granted, then data. Without it: data granted first, then fetch.
- Timeout: TIMEOUT = 4, d_req load with mem_ready held 0 → 4 ACC cycles, then d_ack = 1, d_err = 1, d_rdata = 0, mem_req = 0 in RESP.
- Reset mid-access: rst = 0 during the second ACC cycle → next cycle state IDLE, mem_req = 0, no ack, all outputs at reset values.
- Back-to-back: i_req held high through 3 fetches, mem_ready always 1 → i_ack pulses exactly every 3 cycles, never two consecutive cycles.
